// File: rtl/gate_bist_controller.sv
// rtl/gate_bist_controller.sv - self-test sequencer for a 2-input combinational gate
module gate_bist_controller #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SETTLE_W      = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] op,
    input  logic       result,
    output logic       testIn1,
    output logic       testIn2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] errorCount,
    output logic [1:0] firstFail,
    output logic       firstFailValid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [SETTLE_W-1:0] CNT_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state, state_nxt;
    logic [1:0]          pattern;
    logic [SETTLE_W-1:0] cnt;
    logic [1:0]          op_q;
    logic                expected;
    logic                settle_end;
    logic                start_ok;

    assign settle_end = (cnt == CNT_LAST);
    assign start_ok   = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        expected = 1'b0;
        case (op_q)
            2'b00: expected = pattern[0] & pattern[1];
            2'b01: expected = pattern[0] | pattern[1];
            2'b10: expected = pattern[0] ^ pattern[1];
            2'b11: expected = ~(pattern[0] & pattern[1]);
            default: expected = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = SETTLE;
                SETTLE:  if (settle_end) state_nxt = CHECK;
                CHECK:   state_nxt = (pattern == 2'b11) ? DONE : SETTLE;
                DONE:    if (start) state_nxt = SETTLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Results survive abort so a partial run can still be inspected.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pattern        <= 2'b00;
            cnt            <= '0;
            op_q           <= 2'b00;
            errorCount     <= 3'd0;
            firstFail      <= 2'b00;
            firstFailValid <= 1'b0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start_ok) begin
            op_q           <= op;
            pattern        <= 2'b00;
            cnt            <= '0;
            errorCount     <= 3'd0;
            firstFail      <= 2'b00;
            firstFailValid <= 1'b0;
        end else if (state == SETTLE) begin
            cnt <= settle_end ? '0 : cnt + 1'b1;
        end else if (state == CHECK) begin
            if (result != expected) begin
                errorCount <= errorCount + 3'd1;
                if (!firstFailValid) begin
                    firstFail      <= pattern;
                    firstFailValid <= 1'b1;
                end
            end
            if (pattern != 2'b11) begin
                pattern <= pattern + 2'd1;
            end
        end
    end

    assign busy    = (state == SETTLE) || (state == CHECK);
    assign done    = (state == DONE);
    assign pass    = done && (errorCount == 3'd0);
    assign testIn1 = busy && pattern[0];
    assign testIn2 = busy && pattern[1];

endmodule
